div_sequencer: RTL and testbench

Multi-cycle integer divide/remainder engine for the RV64 pipeline's M-extension ops (DIV, DIVU, REM, REMU and their W variants). It sits beside the execute-stage ALU. It accepts one operation from EX and holds the pipeline via `stall` while it iterates a radix-2 restoring divide, one quotient bit per cycle. It then presents a one-cycle `valid` result for capture into the EX/MEM register. Divide-by-zero and signed overflow complete on a 1-cycle fast path with RISC-V-mandated results.

---
 rtl/div_sequencer_if.sv | 29 ++
 rtl/div_sequencer.sv | 156 +++++++++++++++
 tb/tb_div_sequencer.sv | 251 +++++++++++++++++++++++++
 3 files changed

// File: rtl/div_sequencer_if.sv
// EX-stage <-> divide engine bundle: op request, operands, stall/busy/valid and result.
// Latency: n/a (wires only).
// Backpressure: engine drives stall; EX holds the op stable while stall is high.
interface div_sequencer_if #(
    parameter int XLEN = 64
);
    logic            start;
    logic            flush;
    logic [2:0]      func3;
    logic            word;
    logic [XLEN-1:0] rs1;
    logic [XLEN-1:0] rs2;
    logic            stall;
    logic            busy;
    logic            valid;
    logic [XLEN-1:0] result;

    // Pipeline (EX) side
    modport master (
        output start, flush, func3, word, rs1, rs2,
        input  stall, busy, valid, result
    );

    // Divide engine side
    modport slave (
        input  start, flush, func3, word, rs1, rs2,
        output stall, busy, valid, result
    );
endinterface

// File: rtl/div_sequencer.sv
// Radix-2 restoring divider for RV64 DIV/DIVU/REM/REMU and W variants.
// Latency: valid N+1 cycles after start (N = 64 or 32); div-by-zero/overflow in 1 cycle.
// Backpressure: stall held from accept through iteration; start ignored unless IDLE.
module div_sequencer #(
    parameter int XLEN = 64
) (
    input  logic          clk,
    input  logic          rst_n,
    div_sequencer_if.slave dif
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t          state;
    logic [6:0]      count;
    logic [XLEN-1:0] rem;
    logic [XLEN-1:0] quo;
    logic [XLEN-1:0] dvs;
    logic [XLEN-1:0] result_q;
    logic            neg_q;
    logic            neg_r;
    logic            is_rem;
    logic            is_word;

    // W results are always the sign extension of the low 32 bits
    function automatic logic [XLEN-1:0] finalise(input logic [XLEN-1:0] v, input logic w);
        return w ? {{(XLEN-32){v[31]}}, v[31:0]} : v;
    endfunction

    logic            accept;
    logic            is_signed_in;
    logic            is_rem_in;
    logic [XLEN-1:0] a_eff;
    logic [XLEN-1:0] b_eff;
    logic [XLEN-1:0] a_abs;
    logic [XLEN-1:0] b_abs;
    logic [XLEN-1:0] min_neg;
    logic [XLEN-1:0] spec_res;
    logic            div_zero;
    logic            ovf;

    // Operand preparation and fast-path detection for the op presented by EX
    always_comb begin
        accept       = (state == S_IDLE) & dif.start & ~dif.flush;
        is_signed_in = dif.func3[2] & ~dif.func3[0];
        is_rem_in    = dif.func3[2] & dif.func3[1];
        a_eff        = dif.rs1;
        b_eff        = dif.rs2;
        min_neg      = {1'b1, {(XLEN-1){1'b0}}};
        if (dif.word) begin
            a_eff   = is_signed_in ? {{(XLEN-32){dif.rs1[31]}}, dif.rs1[31:0]}
                                   : {{(XLEN-32){1'b0}}, dif.rs1[31:0]};
            b_eff   = is_signed_in ? {{(XLEN-32){dif.rs2[31]}}, dif.rs2[31:0]}
                                   : {{(XLEN-32){1'b0}}, dif.rs2[31:0]};
            min_neg = {{(XLEN-32){1'b1}}, 32'h8000_0000};
        end
        a_abs    = (is_signed_in & a_eff[XLEN-1]) ? -a_eff : a_eff;
        b_abs    = (is_signed_in & b_eff[XLEN-1]) ? -b_eff : b_eff;
        div_zero = (b_eff == '0);
        ovf      = is_signed_in & (a_eff == min_neg) & (b_eff == '1);
        if (div_zero) begin
            spec_res = is_rem_in ? a_eff : '1;
        end else begin
            spec_res = is_rem_in ? '0 : a_eff;
        end
    end

    logic [XLEN:0]   rem_sh;
    logic [XLEN:0]   diff;
    logic [XLEN-1:0] rem_nx;
    logic [XLEN-1:0] quo_nx;
    logic [XLEN-1:0] q_fix;
    logic [XLEN-1:0] r_fix;
    logic [XLEN-1:0] fin;

    // One restoring step; rem_sh is one bit wider so the trial subtract sees the carry-out
    always_comb begin
        rem_sh = {rem, quo[XLEN-1]};
        diff   = rem_sh - {1'b0, dvs};
        if (!diff[XLEN]) begin
            rem_nx = diff[XLEN-1:0];
            quo_nx = {quo[XLEN-2:0], 1'b1};
        end else begin
            rem_nx = rem_sh[XLEN-1:0];
            quo_nx = {quo[XLEN-2:0], 1'b0};
        end
        q_fix = neg_q ? -quo_nx : quo_nx;
        r_fix = neg_r ? -rem_nx : rem_nx;
        fin   = finalise(is_rem ? r_fix : q_fix, is_word);
    end

    // Control FSM and datapath registers; result is latched on entry to DONE
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            count    <= '0;
            rem      <= '0;
            quo      <= '0;
            dvs      <= '0;
            result_q <= '0;
            neg_q    <= 1'b0;
            neg_r    <= 1'b0;
            is_rem   <= 1'b0;
            is_word  <= 1'b0;
        end else if (dif.flush) begin
            state <= S_IDLE;
        end else begin
            case (state)
                S_IDLE: begin
                    if (dif.start) begin
                        is_rem  <= is_rem_in;
                        is_word <= dif.word;
                        neg_q   <= is_signed_in & (a_eff[XLEN-1] ^ b_eff[XLEN-1]);
                        neg_r   <= is_signed_in & a_eff[XLEN-1];
                        dvs     <= b_abs;
                        rem     <= '0;
                        // W ops park the 32-bit dividend at the top so 32 shifts consume it
                        quo     <= dif.word ? (a_abs << 32) : a_abs;
                        count   <= dif.word ? 7'd32 : 7'd64;
                        if (div_zero | ovf) begin
                            result_q <= finalise(spec_res, dif.word);
                            state    <= S_DONE;
                        end else begin
                            state <= S_BUSY;
                        end
                    end
                end
                S_BUSY: begin
                    rem   <= rem_nx;
                    quo   <= quo_nx;
                    count <= count - 7'd1;
                    if (count == 7'd1) begin
                        result_q <= fin;
                        state    <= S_DONE;
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    assign dif.stall  = accept | (state == S_BUSY);
    assign dif.busy   = (state != S_IDLE);
    assign dif.valid  = (state == S_DONE);
    assign dif.result = result_q;

endmodule

// File: tb/tb_div_sequencer.sv
module tb_div_sequencer;

    localparam logic [2:0] F_DIV  = 3'b100;
    localparam logic [2:0] F_DIVU = 3'b101;
    localparam logic [2:0] F_REM  = 3'b110;
    localparam logic [2:0] F_REMU = 3'b111;

    logic clk;
    logic rst_n;
    int   tests;
    int   fails;

    div_sequencer_if #(.XLEN(64)) dif();

    div_sequencer #(.XLEN(64)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .dif   (dif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // RISC-V M-extension semantics written directly with language division
    function automatic logic [63:0] ref_model(input logic [2:0] f3, input logic w,
                                              input logic [63:0] a, input logic [63:0] b);
        logic        sgn;
        logic        rm;
        int          sa, sb;
        int unsigned ua, ub;
        longint      la, lb;
        logic [31:0] r32;
        logic [63:0] r;
        sgn = f3[2] & ~f3[0];
        rm  = f3[2] & f3[1];
        if (w) begin
            sa = a[31:0]; sb = b[31:0]; ua = a[31:0]; ub = b[31:0];
            if (b[31:0] == 32'd0)                                   r32 = rm ? a[31:0] : 32'hFFFF_FFFF;
            else if (sgn && a[31:0] == 32'h8000_0000 && sb == -1)    r32 = rm ? 32'd0 : 32'h8000_0000;
            else if (sgn)                                           r32 = rm ? sa % sb : sa / sb;
            else                                                    r32 = rm ? ua % ub : ua / ub;
            r = {{32{r32[31]}}, r32};
        end else begin
            la = a; lb = b;
            if (b == 64'd0)                                          r = rm ? a : '1;
            else if (sgn && a == 64'h8000_0000_0000_0000 && lb == -1) r = rm ? 64'd0 : a;
            else if (sgn)                                            r = rm ? la % lb : la / lb;
            else                                                     r = rm ? a % b : a / b;
        end
        return r;
    endfunction

    function automatic bit is_special(input logic [2:0] f3, input logic w,
                                      input logic [63:0] a, input logic [63:0] b);
        logic sgn;
        sgn = f3[2] & ~f3[0];
        if (w) return (b[31:0] == 32'd0) || (sgn && a[31:0] == 32'h8000_0000 && b[31:0] == 32'hFFFF_FFFF);
        return (b == 64'd0) || (sgn && a == 64'h8000_0000_0000_0000 && b == '1);
    endfunction

    // Issue one op, follow it to its valid pulse, check latency/stall/result/hold
    task automatic do_op(input string tag, input logic [2:0] f3, input logic w,
                         input logic [63:0] a, input logic [63:0] b, output logic [63:0] got);
        logic [63:0] exp;
        int lat_exp, lat, stall_cnt;
        exp     = ref_model(f3, w, a, b);
        lat_exp = is_special(f3, w, a, b) ? 1 : (w ? 33 : 65);
        @(posedge clk); #1;
        dif.func3 = f3; dif.word = w; dif.rs1 = a; dif.rs2 = b; dif.start = 1'b1;
        @(negedge clk);
        stall_cnt = (dif.stall === 1'b1) ? 1 : 0;
        lat = -1;
        for (int k = 1; k <= 80; k++) begin
            @(posedge clk); #1;
            dif.start = 1'b0;
            @(negedge clk);
            if (dif.stall === 1'b1) stall_cnt++;
            if (dif.valid === 1'b1) begin
                lat = k;
                break;
            end
        end
        got = dif.result;
        chk({tag, "_lat"},   64'(lat),       64'(lat_exp));
        chk({tag, "_stall"}, 64'(stall_cnt), 64'(lat_exp));
        chk({tag, "_res"},   got,            exp);
        @(negedge clk);
        chk({tag, "_pulse"}, 64'(dif.valid), 64'd0);
        chk({tag, "_idle"},  64'(dif.busy),  64'd0);
        chk({tag, "_hold"},  dif.result,     exp);
    endtask

    initial begin
        logic [63:0] got;
        logic [63:0] a, b;
        logic [2:0]  f3;
        logic        w;
        int          vcnt;
        logic [63:0] vres;

        tests = 0;
        fails = 0;
        rst_n = 1'b0;
        dif.start = 1'b0; dif.flush = 1'b0; dif.func3 = 3'd0; dif.word = 1'b0;
        dif.rs1 = '0; dif.rs2 = '0;

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_busy",   64'(dif.busy),  64'd0);
        chk("rst_valid",  64'(dif.valid), 64'd0);
        chk("rst_stall",  64'(dif.stall), 64'd0);
        chk("rst_result", dif.result,     64'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Directed unsigned / signed / W / fast path
        do_op("divu_100_7", F_DIVU, 1'b0, 64'd100, 64'd7, got);   chk("divu_100_7_k", got, 64'd14);
        do_op("remu_100_7", F_REMU, 1'b0, 64'd100, 64'd7, got);   chk("remu_100_7_k", got, 64'd2);
        do_op("div_m7_2",  F_DIV, 1'b0, -64'sd7, 64'd2, got);     chk("div_m7_2_k",  got, -64'sd3);
        do_op("rem_m7_2",  F_REM, 1'b0, -64'sd7, 64'd2, got);     chk("rem_m7_2_k",  got, -64'sd1);
        do_op("div_7_m2",  F_DIV, 1'b0, 64'd7, -64'sd2, got);     chk("div_7_m2_k",  got, -64'sd3);
        do_op("rem_7_m2",  F_REM, 1'b0, 64'd7, -64'sd2, got);     chk("rem_7_m2_k",  got, 64'd1);
        do_op("divw_min_2", F_DIV, 1'b1, 64'hFFFF_FFFF_8000_0000, 64'd2, got);
        chk("divw_min_2_k", got, 64'hFFFF_FFFF_C000_0000);
        do_op("divuw_fffe", F_DIVU, 1'b1, 64'h0000_0000_FFFF_FFFE, 64'd1, got);
        chk("divuw_fffe_k", got, 64'hFFFF_FFFF_FFFF_FFFE);
        do_op("divu_by0", F_DIVU, 1'b0, 64'h1234_5678_9ABC_DEF0, 64'd0, got);
        chk("divu_by0_k", got, 64'hFFFF_FFFF_FFFF_FFFF);
        do_op("rem_5_0", F_REM, 1'b0, 64'd5, 64'd0, got);         chk("rem_5_0_k", got, 64'd5);
        do_op("div_ovf", F_DIV, 1'b0, 64'h8000_0000_0000_0000, '1, got);
        chk("div_ovf_k", got, 64'h8000_0000_0000_0000);
        do_op("rem_ovf", F_REM, 1'b0, 64'h8000_0000_0000_0000, '1, got);
        chk("rem_ovf_k", got, 64'd0);
        do_op("divw_ovf", F_DIV, 1'b1, 64'h0000_0000_8000_0000, 64'h0000_0000_FFFF_FFFF, got);
        chk("divw_ovf_k", got, 64'hFFFF_FFFF_8000_0000);

        // Flush at t+10 aborts the op
        @(posedge clk); #1;
        dif.func3 = F_DIVU; dif.word = 1'b0; dif.rs1 = 64'd1000; dif.rs2 = 64'd3; dif.start = 1'b1;
        @(posedge clk); #1;
        dif.start = 1'b0;
        repeat (9) @(posedge clk);
        #1 dif.flush = 1'b1;
        @(negedge clk);
        chk("flush_busy_t10", 64'(dif.busy), 64'd1);
        @(posedge clk); #1;
        dif.flush = 1'b0;
        @(negedge clk);
        chk("flush_busy_t11",  64'(dif.busy),  64'd0);
        chk("flush_stall_t11", 64'(dif.stall), 64'd0);
        vcnt = 0;
        for (int k = 0; k < 70; k++) begin
            @(negedge clk);
            if (dif.valid === 1'b1) vcnt++;
        end
        chk("flush_no_valid", 64'(vcnt), 64'd0);

        // start together with flush is not accepted
        @(posedge clk); #1;
        dif.func3 = F_DIVU; dif.rs1 = 64'd50; dif.rs2 = 64'd5; dif.start = 1'b1; dif.flush = 1'b1;
        @(negedge clk);
        chk("sf_stall", 64'(dif.stall), 64'd0);
        @(posedge clk); #1;
        dif.start = 1'b0; dif.flush = 1'b0;
        @(negedge clk);
        chk("sf_busy", 64'(dif.busy), 64'd0);
        vcnt = 0;
        for (int k = 0; k < 70; k++) begin
            @(negedge clk);
            if (dif.valid === 1'b1) vcnt++;
        end
        chk("sf_no_valid", 64'(vcnt), 64'd0);

        // start pulsed during BUSY is ignored
        @(posedge clk); #1;
        dif.func3 = F_DIVU; dif.word = 1'b0; dif.rs1 = 64'd1000; dif.rs2 = 64'd10; dif.start = 1'b1;
        @(posedge clk); #1;
        dif.start = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        dif.func3 = F_REM; dif.rs1 = 64'd7; dif.rs2 = 64'd3; dif.start = 1'b1;
        @(posedge clk); #1;
        dif.start = 1'b0;
        vcnt = 0;
        vres = '0;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (dif.valid === 1'b1) begin
                vcnt++;
                vres = dif.result;
            end
        end
        chk("busy_start_cnt", 64'(vcnt), 64'd1);
        chk("busy_start_res", vres, 64'd100);

        // Reset mid-op clears outputs immediately
        @(posedge clk); #1;
        dif.func3 = F_DIVU; dif.rs1 = 64'd777; dif.rs2 = 64'd7; dif.start = 1'b1;
        @(posedge clk); #1;
        dif.start = 1'b0;
        repeat (19) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("mid_rst_busy",   64'(dif.busy),  64'd0);
        chk("mid_rst_stall",  64'(dif.stall), 64'd0);
        chk("mid_rst_valid",  64'(dif.valid), 64'd0);
        chk("mid_rst_result", dif.result,     64'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        do_op("post_rst_9_3", F_DIVU, 1'b0, 64'd9, 64'd3, got);
        chk("post_rst_9_3_k", got, 64'd3);

        // Randomized ops against the reference model
        for (int i = 0; i < 40; i++) begin
            logic [31:0] r0, r1, r2, r3;
            r0 = $urandom(); r1 = $urandom(); r2 = $urandom(); r3 = $urandom();
            case ($urandom_range(0, 4))
                0: f3 = F_DIV;
                1: f3 = F_DIVU;
                2: f3 = F_REM;
                3: f3 = F_REMU;
                default: f3 = 3'($urandom_range(0, 7));
            endcase
            w = 1'($urandom_range(0, 1));
            a = {r0, r1};
            b = {r2, r3};
            case ($urandom_range(0, 3))
                0: ;
                1: begin
                    a = 64'($signed(r0[7:0]));
                    b = 64'($signed(r2[3:0]));
                end
                2: b = '0;
                default: b = 64'($signed(r3[11:0]));
            endcase
            do_op("rnd", f3, w, a, b, got);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
